// File: rtl/mod6_pkg.sv
// Shared constants and types for the modulo-6 counter and its sequence monitor.
package mod6_pkg;
   localparam int         MOD6_W    = 3;
   localparam logic [2:0] MOD6_LAST = 3'd5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACQ    = 2'd1,
      LOCKED = 2'd2
   } mon_state_t;
endpackage

// File: rtl/mod6_next_value.sv
// Modulo-6 successor and legality of a 3-bit count; shared with the counter itself.
module mod6_next_value
   import mod6_pkg::*;
(
   input  logic [MOD6_W-1:0] q,
   input  logic              en,
   output logic [MOD6_W-1:0] next,
   output logic              legal
);

   always_comb begin
      legal = (q <= MOD6_LAST);
      if (!en)
         next = q;
      else if (q >= MOD6_LAST)
         next = '0;
      else
         next = q + 3'd1;
   end

endmodule

// File: rtl/mod6_sequence_monitor.sv
// Passive checker on a modulo-6 counter: tracks lock, flags sequence errors and
// counts wraps. All outputs come straight from registers.
module mod6_sequence_monitor
   import mod6_pkg::*;
#(
   parameter int LOCK_LEN = 3,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             en,
   input  logic             q0,
   input  logic             q1,
   input  logic             q2,
   output logic             locked,
   output logic             err,
   output logic             wrap,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] wrap_count
);

   localparam logic [3:0] LOCK_RUN = 4'(LOCK_LEN);

   logic [MOD6_W-1:0] q_cur, q_nxt;
   logic              q_legal;

   mon_state_t        state_q, state_d;
   logic [3:0]        run_q, run_d;
   logic [MOD6_W-1:0] prev_val_q, exp_q;
   logic              prev_en_q;
   logic              err_q, err_d, wrap_q, wrap_d, locked_q;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d, wrap_cnt_q, wrap_cnt_d;
   logic              match;

   assign q_cur = {q2, q1, q0};

   // Successor of the current sample is captured as the expectation for the next edge.
   mod6_next_value u_next (
      .q     (q_cur),
      .en    (en),
      .next  (q_nxt),
      .legal (q_legal)
   );

   assign match = (q_cur == exp_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         run_q      <= '0;
         prev_val_q <= '0;
         prev_en_q  <= 1'b0;
         exp_q      <= '0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         wrap_q     <= 1'b0;
         err_cnt_q  <= '0;
         wrap_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         if (q_legal) begin
            prev_val_q <= q_cur;
            prev_en_q  <= en;
            exp_q      <= q_nxt;
         end
         locked_q   <= (state_d == LOCKED);
         err_q      <= err_d;
         wrap_q     <= wrap_d;
         err_cnt_q  <= err_cnt_d;
         wrap_cnt_q <= wrap_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      unique case (state_q)
         IDLE: begin
            if (q_legal) begin
               state_d = ACQ;
               run_d   = '0;
            end
         end
         ACQ: begin
            if (!q_legal) begin
               state_d = IDLE;
               run_d   = '0;
            end else if (match) begin
               run_d = run_q + 4'd1;
               if (run_d == LOCK_RUN) state_d = LOCKED;
            end else begin
               run_d = '0;
            end
         end
         LOCKED: begin
            if (!q_legal) begin
               state_d = IDLE;
               run_d   = '0;
            end else if (!match) begin
               state_d = ACQ;
               run_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            run_d   = '0;
         end
      endcase
   end

   // Errors are only reported once a sample has been loaded; IDLE ignores junk.
   always_comb begin
      err_d  = q_legal ? (state_q == LOCKED && !match) : (state_q != IDLE);
      wrap_d = (state_q == LOCKED) && q_legal && match && prev_en_q &&
               (prev_val_q == MOD6_LAST) && (q_cur == '0);

      if (clr)
         err_cnt_d = '0;
      else if (err_d && (err_cnt_q != '1))
         err_cnt_d = err_cnt_q + 1'b1;
      else
         err_cnt_d = err_cnt_q;

      if (clr)
         wrap_cnt_d = '0;
      else if (wrap_d)
         wrap_cnt_d = wrap_cnt_q + 1'b1;
      else
         wrap_cnt_d = wrap_cnt_q;
   end

   assign locked     = locked_q;
   assign err        = err_q;
   assign wrap       = wrap_q;
   assign err_count  = err_cnt_q;
   assign wrap_count = wrap_cnt_q;

endmodule

// File: tb/tb_mod6_sequence_monitor.sv
// Bench for mod6_sequence_monitor: behavioural model checked every cycle plus
// hand-computed expectations for the directed scenarios.
module tb_mod6_sequence_monitor;
   localparam int LOCK_LEN = 3;

   logic       clk = 1'b0;
   logic       reset_n, clr, en, q0, q1, q2;
   logic       locked, err, wrap;
   logic [7:0] err_count, wrap_count;

   int checks = 0;
   int errors = 0;

   // model state
   int m_mode;   // 0 idle, 1 acquiring, 2 locked
   int m_good, m_pq, m_pen;
   int m_locked, m_err, m_wrap, m_errc, m_wrapc;
   int cnt;

   mod6_sequence_monitor #(.LOCK_LEN(LOCK_LEN), .CNT_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .clr(clr), .en(en),
      .q0(q0), .q1(q1), .q2(q2),
      .locked(locked), .err(err), .wrap(wrap),
      .err_count(err_count), .wrap_count(wrap_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_good = 0; m_pq = 0; m_pen = 0;
      m_locked = 0; m_err = 0; m_wrap = 0; m_errc = 0; m_wrapc = 0;
   endtask

   task automatic model_step(input int qv, input int e, input int c);
      bit legal;
      int expv;
      legal = (qv < 6);
      expv  = m_pen ? (m_pq + 1) % 6 : m_pq;
      m_err = 0; m_wrap = 0;
      if (m_mode == 0) begin
         if (legal) begin m_mode = 1; m_good = 0; end
      end else if (!legal) begin
         m_err = 1; m_mode = 0;
      end else if (qv != expv) begin
         if (m_mode == 2) m_err = 1;
         m_mode = 1; m_good = 0;
      end else if (m_mode == 1) begin
         m_good++;
         if (m_good >= LOCK_LEN) m_mode = 2;
      end else if (m_pq == 5 && m_pen == 1 && qv == 0) begin
         m_wrap = 1;
      end
      if (legal) begin m_pq = qv; m_pen = e; end
      m_locked = (m_mode == 2);
      if (c) m_errc = 0; else if (m_err && m_errc < 255) m_errc++;
      if (c) m_wrapc = 0; else if (m_wrap) m_wrapc = (m_wrapc + 1) % 256;
   endtask

   task automatic compare();
      chk("locked", int'(locked), m_locked);
      chk("err", int'(err), m_err);
      chk("wrap", int'(wrap), m_wrap);
      chk("err_count", int'(err_count), m_errc);
      chk("wrap_count", int'(wrap_count), m_wrapc);
   endtask

   // One sampling edge with explicit inputs, then a model update and compare.
   task automatic cyc(input int qv, input int e, input int c);
      logic [2:0] qb;
      qb = qv[2:0];
      {q2, q1, q0} = qb;
      en = e[0]; clr = c[0];
      @(posedge clk);
      model_step(qv, e, c);
      @(negedge clk);
      compare();
   endtask

   // One edge driven by a correct modulo-6 counter.
   task automatic cnt_cyc(input int e, input int c);
      cyc(cnt, e, c);
      if (e != 0) cnt = (cnt + 1) % 6;
   endtask

   initial begin
      reset_n = 1'b0; clr = 0; en = 0; {q2, q1, q0} = 3'd0;
      model_reset();
      cnt = 0;
      #12;
      chk("reset_locked", int'(locked), 0);
      chk("reset_counts", int'(err_count) + int'(wrap_count), 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Clean counter from 0: lock on the 4th edge, wraps on edges 7, 13, 19.
      for (int i = 0; i < 3; i++) cnt_cyc(1, 0);
      chk("lock_before_4th", int'(locked), 0);
      cnt_cyc(1, 0);
      chk("lock_at_4th", int'(locked), 1);
      for (int i = 0; i < 15; i++) cnt_cyc(1, 0);
      chk("wrap_count_3", int'(wrap_count), 3);
      chk("err_count_clean", int'(err_count), 0);

      // Hold at 3 for one cycle.
      for (int i = 0; i < 6 && cnt != 3; i++) cnt_cyc(1, 0);
      cnt_cyc(0, 0);
      for (int i = 0; i < 4; i++) cnt_cyc(1, 0);
      chk("hold_locked", int'(locked), 1);
      chk("hold_errc", int'(err_count), 0);

      // Illegal value for one edge while the counter keeps running.
      cyc(7, 1, 0);
      cnt = (cnt + 1) % 6;
      chk("force_err", int'(err), 1);
      chk("force_errc", int'(err_count), 1);
      chk("force_unlock", int'(locked), 0);
      for (int i = 0; i < 3; i++) cnt_cyc(1, 0);
      chk("force_relock_early", int'(locked), 0);
      cnt_cyc(1, 0);
      chk("force_relock", int'(locked), 1);

      // Skip 2 -> 4.
      cnt_cyc(1, 1);
      for (int i = 0; i < 6 && cnt != 2; i++) cnt_cyc(1, 0);
      cnt_cyc(1, 0);
      cnt = 4;
      cnt_cyc(1, 0);
      chk("skip_err", int'(err), 1);
      chk("skip_errc", int'(err_count), 1);
      chk("skip_unlock", int'(locked), 0);
      cnt_cyc(1, 0); cnt_cyc(1, 0);
      chk("skip_relock_early", int'(locked), 0);
      cnt_cyc(1, 0);
      chk("skip_relock", int'(locked), 1);

      // Randomized counter with occasional corruption, holds and clears.
      for (int i = 0; i < 1500; i++) begin
         int e, c, r;
         e = ($urandom_range(0, 9) < 7) ? 1 : 0;
         c = ($urandom_range(0, 99) < 3) ? 1 : 0;
         r = $urandom_range(0, 99);
         if (r < 4) begin
            cyc($urandom_range(0, 7), e, c);
            if (e != 0) cnt = (cnt + 1) % 6;
         end else if (r < 6) begin
            cnt = $urandom_range(0, 5);
            cnt_cyc(e, c);
         end else begin
            cnt_cyc(e, c);
         end
      end

      // Saturation: alternate illegal and legal samples 300 times.
      cnt_cyc(1, 1);
      for (int i = 0; i < 300; i++) begin
         cyc(6 + (i % 2), 1, 0);
         cnt_cyc(1, 0);
      end
      chk("sat_errc", int'(err_count), 255);
      cyc(7, 1, 1);
      chk("clr_err_pulse", int'(err), 1);
      chk("clr_errc", int'(err_count), 0);

      // Reach lock with wrap_count 5, then reset between edges.
      cnt = 0;
      cnt_cyc(1, 1);
      for (int i = 0; i < 200 && !(m_wrapc == 5 && m_locked == 1); i++) cnt_cyc(1, 0);
      chk("pre_reset_wrapc", int'(wrap_count), 5);
      chk("pre_reset_locked", int'(locked), 1);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      chk("async_locked", int'(locked), 0);
      chk("async_err_wrap", int'(err) + int'(wrap), 0);
      chk("async_wrapc", int'(wrap_count), 0);
      chk("async_errc", int'(err_count), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
